// File: rtl/ps_hazard_ctrl.sv
// ps_hazard_ctrl: pipeline hazard control for a 4-register (PS1..PS4) in-order pipe.
// It drives the stage register enables and clears and the PC enable, and it handles:
//   - data-memory stalls
//   - load-use bubbles
//   - mispredict flushes
//   - syscall halt/resume
//   - interrupt drain
// Outputs are combinational from the current state and the hazard inputs. They take
// effect at the next clk edge, so they add no latency.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cnt and flush_cnt counters.

module ps_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned DRAIN_CNT_BIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_busy,
  input  logic        mispredict,
  input  logic        load_use,
  input  logic        syscall_halt,
  input  logic        resume,
  input  logic        intr_req,
  output logic        pc_en,
  output logic        ps1_en,
  output logic        ps2_en,
  output logic        ps3_en,
  output logic        ps4_en,
  output logic        ps1_clear,
  output logic        ps2_clear,
  output logic        ps3_clear,
  output logic        ps4_clear,
  output logic        halted,
  output logic        intr_taken
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CW = DRAIN_CNT_BIT;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALT,
    ST_RESUME,
    ST_DRAIN,
    ST_INTR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_mp_flush;

  // State register and drain counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and stage control; everything is held at zero while rst is high
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mp_flush  = 1'b0;
    pc_en       = 1'b0;
    ps1_en      = 1'b0;
    ps2_en      = 1'b0;
    ps3_en      = 1'b0;
    ps4_en      = 1'b0;
    ps1_clear   = 1'b0;
    ps2_clear   = 1'b0;
    ps3_clear   = 1'b0;
    ps4_clear   = 1'b0;
    halted      = 1'b0;
    intr_taken  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN, ST_RESUME: begin
          if (dm_busy) begin
            // Whole pipe frozen; RESUME also waits here
            w_state_nxt = r_state;
          end else if (mispredict) begin
            // Wrong-path IF/ID and ID/EX squashed; any load_use refers to a dead instruction
            pc_en       = 1'b1;
            ps1_en      = 1'b1;
            ps1_clear   = 1'b1;
            ps2_en      = 1'b1;
            ps2_clear   = 1'b1;
            ps3_en      = 1'b1;
            ps4_en      = 1'b1;
            w_mp_flush  = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (syscall_halt && (r_state == ST_RUN)) begin
            // Syscall parks in EX; in RESUME it is masked so it can advance
            w_state_nxt = ST_HALT;
          end else if (intr_req) begin
            // Stop fetching and let PS2..PS4 run out
            ps1_en      = 1'b1;
            ps1_clear   = 1'b1;
            ps2_en      = 1'b1;
            ps3_en      = 1'b1;
            ps4_en      = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ST_DRAIN;
          end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX
            ps2_en      = 1'b1;
            ps2_clear   = 1'b1;
            ps3_en      = 1'b1;
            ps4_en      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            pc_en       = 1'b1;
            ps1_en      = 1'b1;
            ps2_en      = 1'b1;
            ps3_en      = 1'b1;
            ps4_en      = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (resume) begin
            w_state_nxt = ST_RESUME;
          end
        end
        ST_DRAIN: begin
          if (!dm_busy) begin
            ps1_en    = 1'b1;
            ps1_clear = 1'b1;
            ps2_en    = 1'b1;
            ps2_clear = mispredict;
            ps3_en    = 1'b1;
            ps4_en    = 1'b1;
            if (r_cnt == '0) begin
              w_state_nxt = ST_INTR;
            end else begin
              w_cnt_nxt = r_cnt - CW'(1);
            end
          end
        end
        ST_INTR: begin
          // Redirect to the handler; the drained stages are emptied
          intr_taken  = 1'b1;
          pc_en       = 1'b1;
          ps1_en      = 1'b1;
          ps2_en      = 1'b1;
          ps3_en      = 1'b1;
          ps4_en      = 1'b1;
          ps2_clear   = 1'b1;
          ps3_clear   = 1'b1;
          ps4_clear   = 1'b1;
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Stall and mispredict-flush event counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_state != ST_HALT)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_mp_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ps_hazard_ctrl.sv
// Directed bench for ps_hazard_ctrl. Observed vector layout:
//   {pc_en, ps1_en..ps4_en, ps1_clear..ps4_clear, halted, intr_taken}
module tb_ps_hazard_ctrl;

  logic clk;
  logic rst;
  logic dm_busy;
  logic mispredict;
  logic load_use;
  logic syscall_halt;
  logic resume;
  logic intr_req;
  logic pc_en;
  logic ps1_en, ps2_en, ps3_en, ps4_en;
  logic ps1_clear, ps2_clear, ps3_clear, ps4_clear;
  logic halted;
  logic intr_taken;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] V_ZERO  = 11'b00000_0000_00;
  localparam logic [10:0] V_RUN   = 11'b11111_0000_00;
  localparam logic [10:0] V_LU    = 11'b00111_0100_00;
  localparam logic [10:0] V_MP    = 11'b11111_1100_00;
  localparam logic [10:0] V_HALT  = 11'b00000_0000_10;
  localparam logic [10:0] V_DRAIN = 11'b01111_1000_00;
  localparam logic [10:0] V_DRMP  = 11'b01111_1100_00;
  localparam logic [10:0] V_INTR  = 11'b11111_0111_01;

  ps_hazard_ctrl #(
    .DRAIN_CYCLES (3),
    .DRAIN_CNT_BIT(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dm_busy     (dm_busy),
    .mispredict  (mispredict),
    .load_use    (load_use),
    .syscall_halt(syscall_halt),
    .resume      (resume),
    .intr_req    (intr_req),
    .pc_en       (pc_en),
    .ps1_en      (ps1_en),
    .ps2_en      (ps2_en),
    .ps3_en      (ps3_en),
    .ps4_en      (ps4_en),
    .ps1_clear   (ps1_clear),
    .ps2_clear   (ps2_clear),
    .ps3_clear   (ps3_clear),
    .ps4_clear   (ps4_clear),
    .halted      (halted),
    .intr_taken  (intr_taken)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all hazard inputs at once: {dm_busy, mispredict, load_use, syscall_halt, resume, intr_req}
  task automatic drive(input logic [5:0] v);
    {dm_busy, mispredict, load_use, syscall_halt, resume, intr_req} = v;
  endtask

  // Let combinational outputs settle, then compare the control vector
  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    #2;
    obs = {pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
           ps1_clear, ps2_clear, ps3_clear, ps4_clear, halted, intr_taken};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  // Advance one clock; inputs are then changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(6'b000000);
    tick();
    // Reset asserted mid-cycle with a mispredict present
    #2;
    rst = 1'b1;
    drive(6'b010000);
    chk("reset_outputs_zero", V_ZERO);
`ifdef HAZARD_PERF_CNT_EN
    chk32("reset_stall_cnt", stall_cnt, 32'd0);
    chk32("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    tick();
    chk("reset_held", V_ZERO);
    rst = 1'b0;
    drive(6'b000000);
    chk("after_reset_run", V_RUN);
    tick();

    // Single load-use bubble
    drive(6'b001000);
    chk("load_use_bubble", V_LU);
`ifdef HAZARD_PERF_CNT_EN
    chk32("stall_before_lu", stall_cnt, 32'd0);
`endif
    tick();
`ifdef HAZARD_PERF_CNT_EN
    chk32("stall_after_lu", stall_cnt, 32'd1);
`endif
    drive(6'b000000);
    chk("after_bubble_run", V_RUN);
    tick();

    // Persistent load-use repeats the bubble
    drive(6'b001000);
    chk("load_use_rep0", V_LU);
    tick();
    chk("load_use_rep1", V_LU);
    tick();

    // Mispredict beats load-use
    drive(6'b011000);
    chk("mp_over_lu", V_MP);
    tick();

    // Mispredict held off by dm_busy, applied once busy drops
    drive(6'b110000);
    chk("mp_under_busy", V_ZERO);
    tick();
    drive(6'b010000);
    chk("mp_after_busy", V_MP);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    chk32("flush_cnt_two", flush_cnt, 32'd2);
`endif

    // Halt on syscall; intr_req ignored while halted
    drive(6'b000100);
    chk("syscall_cycle", V_ZERO);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive((i == 2) ? 6'b000101 : 6'b000100);
      chk($sformatf("halted_%0d", i), V_HALT);
      tick();
    end
    drive(6'b000110);
    chk("halt_resume_pulse", V_HALT);
    tick();
    // RESUME waits out dm_busy, then passes the masked syscall
    drive(6'b100100);
    chk("resume_busy", V_ZERO);
    tick();
    drive(6'b000100);
    chk("resume_masked_syscall", V_RUN);
    tick();
    drive(6'b000000);
    chk("back_to_run", V_RUN);
    tick();

    // Interrupt drain: entry cycle, three DRAIN cycles, then one INTR pulse
    drive(6'b000001);
    chk("intr_entry", V_DRAIN);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain_%0d", i), V_DRAIN);
      tick();
    end
    chk("intr_taken", V_INTR);
    tick();
    // Still requesting: re-enter DRAIN from one RUN cycle
    chk("intr_reentry", V_DRAIN);
    tick();
    drive(6'b100000);
    chk("drain_busy0", V_ZERO);
    tick();
    chk("drain_busy1", V_ZERO);
    tick();
    drive(6'b000000);
    chk("drain_after_busy0", V_DRAIN);
    tick();
    drive(6'b010000);
    chk("drain_mispredict", V_DRMP);
    tick();
    drive(6'b000000);
    chk("drain_after_busy2", V_DRAIN);
    tick();
    chk("intr_taken_delayed", V_INTR);
    tick();
    chk("run_after_intr", V_RUN);
    tick();

    // Reset in the middle of HALT
    drive(6'b000100);
    chk("syscall_again", V_ZERO);
    tick();
    drive(6'b000000);
    chk("halted_again", V_HALT);
    #2;
    rst = 1'b1;
    chk("reset_mid_halt", V_ZERO);
    tick();
    rst = 1'b0;
    chk("run_after_halt_reset", V_RUN);
    tick();

    // Reset in the middle of DRAIN must not produce intr_taken
    drive(6'b000001);
    chk("intr_entry2", V_DRAIN);
    tick();
    drive(6'b000000);
    chk("drain_before_reset", V_DRAIN);
    rst = 1'b1;
    chk("reset_mid_drain", V_ZERO);
    tick();
    rst = 1'b0;
    chk("run_after_drain_reset0", V_RUN);
    tick();
    chk("run_after_drain_reset1", V_RUN);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
